shuffler_pipe: RTL
==================

Name: shuffler_pipe

Overview:
Parametrised, handshaked successor to the registered brick shuffler in the stripes datapath. It routes OUT_BRICKS output brick busses from IN_BRICKS input brick busses. Each output is chosen by an explicit per-output select or by a rotate offset. Per-output zero masking and out-of-range detection are included. A two-stage valid/ready pipeline with full backpressure sits between the NBin/neuron-memory read path and the serial inner-product units.

Parameters:
BL, 256, brick length in bits
IN_BRICKS, 16, number of input bricks; any value >= 2 (power of two not required)
OUT_BRICKS, 16, number of output bricks; any value >= 1
SEL_BITS, 4, select width per output; must satisfy 2**SEL_BITS >= IN_BRICKS (elaboration error otherwise)

Ports:
clk  in  1  main clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
i_data  in  IN_BRICKS*BL  input bricks; brick k = bits [(k+1)*BL-1 : k*BL]
i_sel  in  SEL_BITS*OUT_BRICKS  per-output select, field j = bits [(j+1)*SEL_BITS-1 : j*SEL_BITS]
i_mode  in  1  0 = explicit select, 1 = rotate
i_rot  in  SEL_BITS  rotate offset (used when i_mode=1)
i_mask  in  OUT_BRICKS  1 = output brick j forced to zero
i_valid  in  1  upstream beat valid
o_ready  out  1  block can accept a beat this cycle
o_data  out  OUT_BRICKS*BL  shuffled output bricks
o_valid  out  1  o_data valid
i_ready  in  1  downstream accepts o_data
o_err  out  1  sticky: an out-of-range index was seen
i_err_clr  in  1  synchronous clear of o_err

Behaviour:
- Reset (rst_n=0, asynchronous): s1_valid=0, s2_valid=0, o_valid=0, o_data=0, o_err=0, and all pipeline data/control registers = 0. The first accept can occur on the first clock edge after rst_n deasserts.
- Stage 1 (capture): registers i_data, i_sel, i_mode, i_rot, i_mask when a beat is accepted.
- Stage 2 (output): registers the mux result computed from the stage-1 contents.
- Latency: 2 cycles from an accepted beat to o_valid, with no stalls.
- Advance enables:
  - en2 = ~s2_valid | i_ready
  - en1 = ~s1_valid | en2
  - o_ready = en1 (combinational from i_ready and the valid bits)
- Accept: occurs when i_valid & o_ready.
  - s1_valid <= i_valid whenever en1.
  - s2_valid <= s1_valid whenever en2.
- Stall: a stage whose enable is 0 holds its data and valid unchanged.
  - o_data must stay stable while o_valid=1 and i_ready=0.
- Throughput: 1 beat/cycle when i_ready is held at 1.
  - Simultaneous accept and drain in the same cycle is legal and loses no beat.
- Index per output j:
  - explicit mode: idx_j = sel_j
  - rotate mode: idx_j = (j + rot) mod IN_BRICKS, computed at width SEL_BITS+1 with no overflow, valid only when rot < IN_BRICKS
- Output brick j:
  - zero if mask_j = 1
  - else zero if the index is out of range (sel_j >= IN_BRICKS in explicit mode, or rot >= IN_BRICKS in rotate mode)
  - else input brick idx_j
- Broadcast: several outputs selecting the same input is legal.
- o_err:
  - Set on the stage-2 load (en2 & s1_valid) of any unmasked output with an out-of-range index. Masked outputs never set o_err.
  - Cleared by i_err_clr. When set and clear coincide, set wins.
- Bubbles: o_data is not updated when s1_valid=0 at en2; only o_valid drops.
- Reset mid-operation: all in-flight beats are discarded and o_valid drops immediately (asynchronously).

Test Plan:
1. Identity, default params: i_mode=0, sel_j=j, mask=0, brick k = {BL/8{8'hk}}, i_valid=1, i_ready=1 → o_valid rises 2 cycles after accept and out brick j = input brick j; 1 beat/cycle over 32 back-to-back beats with no gaps.
2. Rotate: i_mode=1, i_rot=3 → out brick 0 = in brick 3, out brick 13 = in brick 0, out brick 15 = in brick 2; o_err stays 0.
3. Backpressure: stream beats 0..9, with i_ready=0 for cycles 4-8 → o_ready goes low once both stages are full, o_data holds beat 2 stable, and all 10 beats emerge in order exactly once after i_ready returns.
4. Non-power-of-two, IN_BRICKS=12, SEL_BITS=4: sel_0=13 with mask_0=0 → out brick 0 = 0 and o_err=1; sel_1=14 with mask_1=1 → out brick 1 = 0; assert i_err_clr with no new error → o_err=0; assert i_err_clr together with a new error → o_err stays 1.
5. Mask and broadcast: all sel_j=5, mask=16'hA5A5 → unmasked outputs equal in brick 5, masked outputs = 0.
6. Reset mid-stream: pull rst_n low while both stages are valid → o_valid=0, o_data=0, o_err=0 immediately; the first beat after release appears 2 cycles after its accept.

Source files
------------

// File: rtl/shuffler_pipe.sv
// Two-stage valid/ready brick shuffler: each output brick comes from an explicit
// per-output select or a rotate offset, with per-output masking and sticky range error.
module shuffler_pipe #(
    parameter int BL         = 256,
    parameter int IN_BRICKS  = 16,
    parameter int OUT_BRICKS = 16,
    parameter int SEL_BITS   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [IN_BRICKS*BL-1:0]        i_data,
    input  logic [SEL_BITS*OUT_BRICKS-1:0] i_sel,
    input  logic                           i_mode,
    input  logic [SEL_BITS-1:0]            i_rot,
    input  logic [OUT_BRICKS-1:0]          i_mask,
    input  logic                           i_valid,
    output logic                           o_ready,
    output logic [OUT_BRICKS*BL-1:0]       o_data,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic                           o_err,
    input  logic                           i_err_clr
);

    generate
        if ((1 << SEL_BITS) < IN_BRICKS) begin : g_bad_sel_bits
            $error("shuffler_pipe: SEL_BITS too narrow to address IN_BRICKS inputs");
        end
        if (IN_BRICKS < 2) begin : g_bad_in_bricks
            $error("shuffler_pipe: IN_BRICKS must be at least 2");
        end
    endgenerate

    localparam logic [SEL_BITS:0] INB = (SEL_BITS+1)'(IN_BRICKS);

    logic                           s1_valid_q;
    logic [IN_BRICKS*BL-1:0]        s1_data_q;
    logic [SEL_BITS*OUT_BRICKS-1:0] s1_sel_q;
    logic                           s1_mode_q;
    logic [SEL_BITS-1:0]            s1_rot_q;
    logic [OUT_BRICKS-1:0]          s1_mask_q;
    logic                           s2_valid_q;
    logic [OUT_BRICKS*BL-1:0]       s2_data_q;
    logic [OUT_BRICKS*BL-1:0]       s2_data_d;
    logic                           err_q;
    logic                           err_d;
    logic [OUT_BRICKS-1:0]          oor;
    logic                           en1;
    logic                           en2;

    assign en2     = ~s2_valid_q | i_ready;
    assign en1     = ~s1_valid_q | en2;
    assign o_ready = en1;
    assign o_valid = s2_valid_q;
    assign o_data  = s2_data_q;
    assign o_err   = err_q;

    function automatic logic [BL-1:0] pick(input logic [IN_BRICKS*BL-1:0] d,
                                           input logic [SEL_BITS:0]       idx);
        logic [BL-1:0] r;
        r = '0;
        for (int k = 0; k < IN_BRICKS; k++) begin
            if (idx == (SEL_BITS+1)'(k)) r = d[k*BL +: BL];
        end
        return r;
    endfunction

    generate
        for (genvar gi = 0; gi < OUT_BRICKS; gi++) begin : g_out
            // Output position folded into input range so the rotated sum stays below 2*IN_BRICKS.
            localparam logic [SEL_BITS:0] JMOD = (SEL_BITS+1)'(gi % IN_BRICKS);
            logic [SEL_BITS:0] sel_ext;
            logic [SEL_BITS:0] rot_sum;
            logic [SEL_BITS:0] idx;

            assign sel_ext = {1'b0, s1_sel_q[gi*SEL_BITS +: SEL_BITS]};
            assign rot_sum = {1'b0, s1_rot_q} + JMOD;
            assign idx     = s1_mode_q ? ((rot_sum >= INB) ? rot_sum - INB : rot_sum) : sel_ext;
            assign oor[gi] = s1_mode_q ? ({1'b0, s1_rot_q} >= INB) : (sel_ext >= INB);
            assign s2_data_d[gi*BL +: BL] = (s1_mask_q[gi] | oor[gi]) ? '0 : pick(s1_data_q, idx);
        end
    endgenerate

    // A fresh error on this edge outranks a coincident clear.
    assign err_d = (en2 & s1_valid_q & |(oor & ~s1_mask_q)) | (err_q & ~i_err_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_sel_q   <= '0;
            s1_mode_q  <= 1'b0;
            s1_rot_q   <= '0;
            s1_mask_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            if (en1) begin
                s1_valid_q <= i_valid;
                if (i_valid) begin
                    s1_data_q <= i_data;
                    s1_sel_q  <= i_sel;
                    s1_mode_q <= i_mode;
                    s1_rot_q  <= i_rot;
                    s1_mask_q <= i_mask;
                end
            end
            if (en2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) s2_data_q <= s2_data_d;
            end
            err_q <= err_d;
        end
    end

endmodule
